alureg_seq: RTL and testbench
=============================

Name: alureg_seq

Overview:
- Control sequencer sitting directly upstream of the alureg datapath.
- Accepts opcode and operand bytes from the fetch path over a valid/ready handshake.
- Classifies each opcode and drives the alureg data bus and strobes (code load, data load, register read, register write) in the fixed order alureg requires.
- Flags illegal opcodes, halts on HLT and counts retired instructions.

Parameters:
- DATASIZE, 8, width of opcode/data bytes and of the alureg data bus.
- CNTSIZE, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- iVLD  input  1  fetch byte valid
- iBYT  input  DATASIZE  fetch byte
- oRDY  output  1  sequencer ready to accept a byte
- oDAT  output  DATASIZE  data bus to alureg
- oENC  output  1  load instruction register strobe
- oEND  output  1  load temp register strobe
- oRRD  output  1  register read enable
- oRWR  output  1  register write enable
- oHLT  output  1  halted
- oERR  output  1  one-cycle illegal-opcode pulse
- oCNT  output  CNTSIZE  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset: state IDLE; oRDY=1; oDAT=0; oENC=oEND=oRRD=oRWR=oHLT=oERR=0; oCNT=0. Reset asserted mid-instruction aborts the instruction immediately and does not increment oCNT.
- Handshake:
  - A byte is accepted on a rising edge where iVLD&oRDY=1.
  - oRDY is high only in IDLE and WAITD.
  - The source must hold iBYT stable while iVLD=1 and oRDY=0.
  - All outputs are registered.
- Opcode decode (bits 7:6 = class, 5:3 = dst/op, 2:0 = src):
  - 0x76 is HLT.
  - Class 01 (MOV) and class 10 (ALU) are legal.
  - Class 00 and class 11 are illegal.
  - A legal opcode with src=110 needs one operand byte; the operand is loaded into the temp register and read as M.
- FSM states:
  - IDLE: oRDY=1. On accept, the opcode is captured into oDAT.
    - If illegal: oERR=1 for the next cycle, stay IDLE, no strobes, oCNT unchanged.
    - Otherwise go to LDC.
  - LDC: oENC=1 for exactly one cycle, oDAT=opcode.
    - HLT goes to HALT.
    - Opcode needing an operand goes to WAITD.
    - All others go to RD.
  - WAITD: oRDY=1, waits indefinitely. On accept, oDAT=operand and go to LDD.
  - LDD: oEND=1 for one cycle, then RD.
  - RD: oRRD=1 for one cycle, then WR.
  - WR: oRRD=1 and oRWR=1 for one cycle, then IDLE. oCNT increments on leaving WR.
  - HALT: oHLT=1, oRDY=0, no strobes. Left only by reset. HLT increments oCNT once on entry.
- Strobe rules:
  - oENC, oEND and oRWR are mutually exclusive.
  - oRRD and oRWR drop together at the end of WR.
  - oDAT holds its last value outside LDC/LDD.
- Latency, counted from the accept edge to the return to IDLE:
  - Register-source instruction: 3 cycles (LDC, RD, WR).
  - Operand instruction: 5 cycles, plus any WAITD stall.
- oCNT wraps from all-ones to 0 without flagging.
- A second byte presented while busy is not accepted (oRDY=0); there is no buffering.

Test Plan:
- Reset behaviour: reset, then send 0x7E followed by 0xAA (MOV A,M plus operand) -> oENC pulse with oDAT=7E, then oRDY=1 in WAITD, oEND pulse with oDAT=AA, then RRD for 1 cycle, then RRD+RWR for 1 cycle; oCNT=1. alureg A=AA.
- Back-to-back register moves: 0x47 (MOV B,A), then 0xAF (XRA A), then 0x4F (MOV C,A) with iVLD held high -> each takes 4 cycles from accept to next accept; oCNT=4. alureg B=AA, A=00, C=00.
- Illegal opcode: 0x3E (class 00) -> oERR high for exactly one cycle, no strobes, oCNT unchanged. Then 0x78 executes normally.
- Operand stall: send 0x86 (ADD M), hold iVLD low for 5 cycles in WAITD -> outputs hold and oRDY=1. Then operand 0x01 proceeds to LDD.
- Halt: 0x76 -> single oENC pulse, then oHLT=1 and oRDY=0 for 20 cycles with iVLD=1; oCNT incremented once. Reset clears oHLT.
- Reset in flight: assert rst asynchronously mid-RD -> oRRD falls immediately (before the next edge), state IDLE, oCNT unchanged. CNTSIZE=2: 5 instructions -> oCNT=1.

Source files
------------

// File: rtl/alureg_seq.sv
// Control sequencer feeding the alureg datapath: accepts opcode/operand
// bytes over valid/ready and emits the code/data/read/write strobes in order.
module alureg_seq #(
  parameter int DATASIZE = 8,
  parameter int CNTSIZE  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iVLD,
  input  logic [DATASIZE-1:0] iBYT,
  output logic                oRDY,
  output logic [DATASIZE-1:0] oDAT,
  output logic                oENC,
  output logic                oEND,
  output logic                oRRD,
  output logic                oRWR,
  output logic                oHLT,
  output logic                oERR,
  output logic [CNTSIZE-1:0]  oCNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDC,
    S_WAITD,
    S_LDD,
    S_RD,
    S_WR,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [DATASIZE-1:0] dat_q, dat_d;
  logic [CNTSIZE-1:0]  cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                enc_q, enc_d;
  logic                end_q, end_d;
  logic                rrd_q, rrd_d;
  logic                rwr_q, rwr_d;
  logic                hlt_q, hlt_d;
  logic                err_q, err_d;

  logic accept;
  logic byt_legal;
  logic op_hlt;
  logic op_mem;

  assign accept    = iVLD & rdy_q;
  assign byt_legal = (iBYT[7:6] == 2'b01) || (iBYT[7:6] == 2'b10);
  // dat_q still holds the opcode while in LDC
  assign op_hlt    = (dat_q == DATASIZE'(8'h76));
  assign op_mem    = (dat_q[2:0] == 3'b110);

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (byt_legal) begin
            dat_d   = iBYT;
            state_d = S_LDC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LDC: begin
        if (op_hlt) begin
          state_d = S_HALT;
          cnt_d   = cnt_q + CNTSIZE'(1);
        end else if (op_mem) begin
          state_d = S_WAITD;
        end else begin
          state_d = S_RD;
        end
      end
      S_WAITD: begin
        if (accept) begin
          dat_d   = iBYT;
          state_d = S_LDD;
        end
      end
      S_LDD: state_d = S_RD;
      S_RD:  state_d = S_WR;
      S_WR: begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + CNTSIZE'(1);
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered copies decoded from the next state
    rdy_d = (state_d == S_IDLE) || (state_d == S_WAITD);
    enc_d = (state_d == S_LDC);
    end_d = (state_d == S_LDD);
    rrd_d = (state_d == S_RD) || (state_d == S_WR);
    rwr_d = (state_d == S_WR);
    hlt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dat_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      enc_q   <= 1'b0;
      end_q   <= 1'b0;
      rrd_q   <= 1'b0;
      rwr_q   <= 1'b0;
      hlt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      enc_q   <= enc_d;
      end_q   <= end_d;
      rrd_q   <= rrd_d;
      rwr_q   <= rwr_d;
      hlt_q   <= hlt_d;
      err_q   <= err_d;
    end
  end

  assign oRDY = rdy_q;
  assign oDAT = dat_q;
  assign oENC = enc_q;
  assign oEND = end_q;
  assign oRRD = rrd_q;
  assign oRWR = rwr_q;
  assign oHLT = hlt_q;
  assign oERR = err_q;
  assign oCNT = cnt_q;

endmodule

// File: tb/tb_alureg_seq.sv
// Directed bench for alureg_seq; a second instance with a 2-bit
// counter shares the stimulus to exercise counter wrap.
module tb_alureg_seq;

  logic       clk;
  logic       rst;
  logic       iVLD;
  logic [7:0] iBYT;

  logic       oRDY, oENC, oEND, oRRD, oRWR, oHLT, oERR;
  logic [7:0] oDAT;
  logic [15:0] oCNT;

  logic       rdy2, enc2, end2, rrd2, rwr2, hlt2, err2;
  logic [7:0] dat2;
  logic [1:0] cnt2;

  int nchk;
  int nerr;

  alureg_seq #(.DATASIZE(8), .CNTSIZE(16)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .iVLD (iVLD),
    .iBYT (iBYT),
    .oRDY (oRDY),
    .oDAT (oDAT),
    .oENC (oENC),
    .oEND (oEND),
    .oRRD (oRRD),
    .oRWR (oRWR),
    .oHLT (oHLT),
    .oERR (oERR),
    .oCNT (oCNT)
  );

  alureg_seq #(.DATASIZE(8), .CNTSIZE(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .iVLD (iVLD),
    .iBYT (iBYT),
    .oRDY (rdy2),
    .oDAT (dat2),
    .oENC (enc2),
    .oEND (end2),
    .oRRD (rrd2),
    .oRWR (rwr2),
    .oHLT (hlt2),
    .oERR (err2),
    .oCNT (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag,
                         input logic [3:0] exp);
    chk(tag, {28'd0, oENC, oEND, oRRD, oRWR}, {28'd0, exp});
  endtask

  // register-source instruction, iVLD left high on return
  task automatic run_reg(input logic [7:0] op,
                         input logic [15:0] cnt);
    iVLD = 1'b1;
    iBYT = op;
    step();
    strobes("reg_ldc", 4'b1000);
    chk("reg_dat", oDAT, op);
    chk("reg_rdy_busy", oRDY, 1'b0);
    step();
    strobes("reg_rd", 4'b0010);
    step();
    strobes("reg_wr", 4'b0011);
    step();
    strobes("reg_idle", 4'b0000);
    chk("reg_cnt", oCNT, cnt);
    chk("reg_rdy", oRDY, 1'b1);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    iVLD = 1'b0;
    iBYT = 8'h00;
    #12;
    chk("rst_rdy", oRDY, 1'b1);
    chk("rst_dat", oDAT, 8'h00);
    strobes("rst_strb", 4'b0000);
    chk("rst_hlt", oHLT, 1'b0);
    chk("rst_err", oERR, 1'b0);
    chk("rst_cnt", oCNT, 16'd0);
    step();
    rst = 1'b0;
    step();

    // MOV A,M with operand AA
    iVLD = 1'b1;
    iBYT = 8'h7E;
    step();
    strobes("m_ldc", 4'b1000);
    chk("m_ldc_dat", oDAT, 8'h7E);
    iBYT = 8'hAA;
    step();
    chk("m_wait_rdy", oRDY, 1'b1);
    strobes("m_wait", 4'b0000);
    step();
    strobes("m_ldd", 4'b0100);
    chk("m_ldd_dat", oDAT, 8'hAA);
    iVLD = 1'b0;
    step();
    strobes("m_rd", 4'b0010);
    step();
    strobes("m_wr", 4'b0011);
    step();
    strobes("m_idle", 4'b0000);
    chk("m_cnt", oCNT, 16'd1);

    // back-to-back register ops, iVLD held high
    run_reg(8'h47, 16'd2);
    run_reg(8'hAF, 16'd3);
    run_reg(8'h4F, 16'd4);
    chk("wrap_cnt0", cnt2, 2'd0);

    // illegal opcode
    iBYT = 8'h3E;
    step();
    chk("ill_err", oERR, 1'b1);
    strobes("ill_strb", 4'b0000);
    chk("ill_rdy", oRDY, 1'b1);
    chk("ill_cnt", oCNT, 16'd4);
    iVLD = 1'b0;
    step();
    chk("ill_err_off", oERR, 1'b0);
    run_reg(8'h78, 16'd5);
    chk("wrap_cnt1", cnt2, 2'd1);
    iVLD = 1'b0;

    // ADD M with a stalled operand
    step();
    iVLD = 1'b1;
    iBYT = 8'h86;
    step();
    strobes("st_ldc", 4'b1000);
    iVLD = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("st_rdy", oRDY, 1'b1);
      chk("st_dat", oDAT, 8'h86);
      strobes("st_strb", 4'b0000);
      step();
    end
    iVLD = 1'b1;
    iBYT = 8'h01;
    step();
    strobes("st_ldd", 4'b0100);
    chk("st_ldd_dat", oDAT, 8'h01);
    iVLD = 1'b0;
    step();
    step();
    step();
    chk("st_cnt", oCNT, 16'd6);

    // reset asserted during RD
    iVLD = 1'b1;
    iBYT = 8'h47;
    step();
    iVLD = 1'b0;
    step();
    chk("rf_rrd_on", oRRD, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rf_rrd_async", oRRD, 1'b0);
    chk("rf_rdy", oRDY, 1'b1);
    rst = 1'b0;
    step();
    step();
    strobes("rf_idle", 4'b0000);
    chk("rf_cnt", oCNT, 16'd0);

    // halt
    iVLD = 1'b1;
    iBYT = 8'h76;
    step();
    strobes("h_ldc", 4'b1000);
    chk("h_dat", oDAT, 8'h76);
    iBYT = 8'h47;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("h_hlt", oHLT, 1'b1);
      chk("h_rdy", oRDY, 1'b0);
      strobes("h_strb", 4'b0000);
      chk("h_cnt", oCNT, 16'd1);
    end
    iVLD = 1'b0;
    rst  = 1'b1;
    #1;
    chk("h_rst_hlt", oHLT, 1'b0);
    chk("h_rst_rdy", oRDY, 1'b1);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
